// File: rtl/lathe_cycle_ctrl.sv
// Spindle/cycle controller for the manual-lathe retrofit: latched manual run,
// or an auto job of warning delay followed by N timed run/dwell repetitions.
module lathe_cycle_ctrl #(
  parameter int TIMER_W     = 24,
  parameter int DELAY_TICKS = 100,
  parameter int DWELL_TICKS = 50,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               estop,
  input  logic               auto_mode,
  input  logic               man_mode,
  input  logic [TIMER_W-1:0] run_ticks,
  input  logic [CNT_W-1:0]   n_reps,
  output logic               spindle_en,
  output logic               warn_lamp,
  output logic               cycle_done,
  output logic               fault,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MAN_RUN    = 3'd1,
    S_AUTO_DELAY = 3'd2,
    S_AUTO_RUN   = 3'd3,
    S_AUTO_DWELL = 3'd4,
    S_FAULT      = 3'd5
  } state_e;

  localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(DELAY_TICKS - 1);
  localparam logic [TIMER_W-1:0] DWELL_LAST = TIMER_W'(DWELL_TICKS - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0]   n_reps_q, n_reps_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               start_q;
  logic               spindle_en_q, spindle_en_d;
  logic               warn_lamp_q, warn_lamp_d;
  logic               cycle_done_q, cycle_done_d;
  logic               fault_q, fault_d;

  logic start_acc;
  logic mode_ok;
  logic job_load;
  logic rep_end;
  logic job_done;
  logic timed_next;

  assign start_acc = start & ~start_q;
  assign mode_ok   = auto_mode ^ man_mode;
  assign cnt_inc   = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;

  // NOTE: async reset clears every flop, including the latched job parameters,
  // and all state uses non-blocking assignments so flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      run_len_q    <= '0;
      n_reps_q     <= '0;
      cycle_cnt_q  <= '0;
      start_q      <= 1'b0;
      spindle_en_q <= 1'b0;
      warn_lamp_q  <= 1'b0;
      cycle_done_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      run_len_q    <= run_len_d;
      n_reps_q     <= n_reps_d;
      cycle_cnt_q  <= cycle_cnt_d;
      start_q      <= start;
      spindle_en_q <= spindle_en_d;
      warn_lamp_q  <= warn_lamp_d;
      cycle_done_q <= cycle_done_d;
      fault_q      <= fault_d;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    job_load = 1'b0;
    rep_end  = 1'b0;
    job_done = 1'b0;
    if (estop) begin
      state_d = S_FAULT;
    end else if (stop) begin
      state_d = S_IDLE;
    end else if (state_q == S_MAN_RUN && !man_mode) begin
      state_d = S_IDLE;
    end else if ((state_q == S_AUTO_DELAY || state_q == S_AUTO_RUN ||
                  state_q == S_AUTO_DWELL) && !auto_mode) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_acc && mode_ok) begin
            if (man_mode) begin
              state_d = S_MAN_RUN;
            end else if (n_reps != '0) begin
              state_d  = S_AUTO_DELAY;
              job_load = 1'b1;
            end
          end
        end
        S_AUTO_DELAY: begin
          if (timer_q == DELAY_LAST) state_d = S_AUTO_RUN;
        end
        S_AUTO_RUN: begin
          if (timer_q == run_len_q - TIMER_ONE) begin
            rep_end = 1'b1;
            if (cnt_inc == n_reps_q) begin
              state_d  = S_IDLE;
              job_done = 1'b1;
            end else begin
              state_d = S_AUTO_DWELL;
            end
          end
        end
        S_AUTO_DWELL: begin
          if (timer_q == DWELL_LAST) state_d = S_AUTO_RUN;
        end
        S_MAN_RUN, S_FAULT: state_d = state_q;
        default:            state_d = S_IDLE;
      endcase
    end
  end

  // Job datapath: shared timer restarts whenever a timed state is (re)entered.
  always_comb begin
    timed_next  = (state_d == S_AUTO_DELAY) || (state_d == S_AUTO_RUN) ||
                  (state_d == S_AUTO_DWELL);
    timer_d     = (timed_next && state_d == state_q) ? timer_q + TIMER_ONE : '0;
    run_len_d   = run_len_q;
    n_reps_d    = n_reps_q;
    cycle_cnt_d = cycle_cnt_q;
    if (job_load) begin
      run_len_d   = (run_ticks == '0) ? TIMER_ONE : run_ticks;
      n_reps_d    = n_reps;
      cycle_cnt_d = '0;
    end else if (rep_end) begin
      cycle_cnt_d = cnt_inc;
    end
  end

  // Outputs decode the next state so they change on the same edge as state.
  always_comb begin
    spindle_en_d = (state_d == S_MAN_RUN) || (state_d == S_AUTO_RUN);
    warn_lamp_d  = (state_d == S_AUTO_DELAY);
    fault_d      = (state_d == S_FAULT);
    cycle_done_d = job_done;
  end

  assign spindle_en = spindle_en_q;
  assign warn_lamp  = warn_lamp_q;
  assign cycle_done = cycle_done_q;
  assign fault      = fault_q;
  assign state      = state_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_lathe_cycle_ctrl.sv
// Bench for lathe_cycle_ctrl: directed vector table, hand-written corner
// sequences, then random stimulus against a job-level reference model.
module tb_lathe_cycle_ctrl;
  localparam int TW = 24;
  localparam int CW = 8;
  localparam int D  = 4;
  localparam int W  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_MAN   = 1;
  localparam int M_AUTO  = 2;
  localparam int M_FAULT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, estop, auto_mode, man_mode;
  logic [TW-1:0] run_ticks;
  logic [CW-1:0] n_reps;
  logic          spindle_en, warn_lamp, cycle_done, fault;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt;

  lathe_cycle_ctrl #(
    .TIMER_W(TW), .DELAY_TICKS(D), .DWELL_TICKS(W), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .estop(estop),
    .auto_mode(auto_mode), .man_mode(man_mode), .run_ticks(run_ticks),
    .n_reps(n_reps), .spindle_en(spindle_en), .warn_lamp(warn_lamp),
    .cycle_done(cycle_done), .fault(fault), .state(state), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the job as elapsed cycles since the auto start
  // and derives phase and completed repetitions arithmetically.
  int m_mode, m_e, m_r, m_n, m_cnt, m_state;
  bit m_prev, m_done;

  task automatic model_reset();
    m_mode = M_IDLE; m_e = 0; m_r = 1; m_n = 1; m_cnt = 0; m_state = 0;
    m_prev = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    int k, p;
    acc    = start && !m_prev;
    m_prev = start;
    m_done = 1'b0;
    if (estop) m_mode = M_FAULT;
    else if (stop) m_mode = M_IDLE;
    else if (m_mode == M_MAN && !man_mode) m_mode = M_IDLE;
    else if (m_mode == M_AUTO && !auto_mode) m_mode = M_IDLE;
    else if (m_mode == M_AUTO) begin
      m_e++;
      if (m_e == D + m_n * m_r + (m_n - 1) * W) begin
        m_mode = M_IDLE; m_done = 1'b1; m_cnt = m_n;
      end
    end else if (m_mode == M_IDLE && acc && (auto_mode != man_mode)) begin
      if (man_mode) m_mode = M_MAN;
      else if (n_reps != 0) begin
        m_mode = M_AUTO; m_e = 0;
        m_r = (run_ticks == 0) ? 1 : int'(run_ticks);
        m_n = int'(n_reps);
      end
    end
    case (m_mode)
      M_IDLE:  m_state = 0;
      M_MAN:   m_state = 1;
      M_FAULT: m_state = 5;
      default: begin
        if (m_e < D) begin
          m_state = 2; m_cnt = 0;
        end else begin
          k = m_e - D;
          p = m_r + W;
          if (k % p < m_r) begin m_state = 3; m_cnt = k / p; end
          else begin m_state = 4; m_cnt = k / p + 1; end
        end
      end
    endcase
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("model state", 32'(state), 32'(m_state));
    check("model spindle_en", 32'(spindle_en), 32'(m_state == 1 || m_state == 3));
    check("model warn_lamp", 32'(warn_lamp), 32'(m_state == 2));
    check("model fault", 32'(fault), 32'(m_state == 5));
    check("model cycle_done", 32'(cycle_done), 32'(m_done));
    check("model cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
  endtask

  task automatic set_in(input logic s, input logic sp, input logic es, input logic am,
                        input logic mm, input int rt, input int nr);
    start = s; stop = sp; estop = es; auto_mode = am; man_mode = mm;
    run_ticks = TW'(rt); n_reps = CW'(nr);
  endtask

  typedef struct {
    logic s, sp, es, am, mm;
    int   rt, nr;
    int   e_state;
    logic e_sp, e_warn, e_done, e_fault;
    int   e_cnt;
  } vec_t;

  function automatic vec_t row(input logic s, sp, es, am, mm, input int rt, nr,
                               input int est, input logic esp, ew, ed, ef, input int ec);
    vec_t v;
    v.s = s; v.sp = sp; v.es = es; v.am = am; v.mm = mm; v.rt = rt; v.nr = nr;
    v.e_state = est; v.e_sp = esp; v.e_warn = ew; v.e_done = ed; v.e_fault = ef;
    v.e_cnt = ec;
    return v;
  endfunction

  vec_t          tv[$];
  logic [16:0]   spin_got, warn_got, spin_exp, warn_exp;
  logic          done_seen;
  logic [2:0]    mr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            s sp es am mm rt nr | st sp w  d  f  cnt
    tv.push_back(row(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(1, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0));
    tv.push_back(row(1, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0));
    tv.push_back(row(0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(1, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(row(1, 0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 1, 0, 0, 1,  3, 1, 0, 0, 0, 0));
    tv.push_back(row(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 1));
    tv.push_back(row(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    tv.push_back(row(0, 0, 1, 1, 0, 0, 1,  5, 0, 0, 0, 1, 1));
    tv.push_back(row(0, 1, 1, 1, 0, 0, 1,  5, 0, 0, 0, 1, 1));
    tv.push_back(row(0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    tv.push_back(row(1, 0, 0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 1));
    tv.push_back(row(0, 0, 1, 0, 1, 0, 1,  5, 0, 0, 0, 1, 1));
    tv.push_back(row(1, 0, 0, 0, 1, 0, 1,  5, 0, 0, 0, 1, 1));
    tv.push_back(row(0, 1, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 1));

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #7;
    check("reset state", 32'(state), 0);
    check("reset spindle_en", 32'(spindle_en), 0);
    check("reset warn_lamp", 32'(warn_lamp), 0);
    check("reset cycle_done", 32'(cycle_done), 0);
    check("reset fault", 32'(fault), 0);
    check("reset cycle_cnt", 32'(cycle_cnt), 0);
    #5 rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      set_in(tv[i].s, tv[i].sp, tv[i].es, tv[i].am, tv[i].mm, tv[i].rt, tv[i].nr);
      cyc();
      check($sformatf("vec%0d state", i), 32'(state), 32'(tv[i].e_state));
      check($sformatf("vec%0d spindle_en", i), 32'(spindle_en), 32'(tv[i].e_sp));
      check($sformatf("vec%0d warn_lamp", i), 32'(warn_lamp), 32'(tv[i].e_warn));
      check($sformatf("vec%0d cycle_done", i), 32'(cycle_done), 32'(tv[i].e_done));
      check($sformatf("vec%0d fault", i), 32'(fault), 32'(tv[i].e_fault));
      check($sformatf("vec%0d cycle_cnt", i), 32'(cycle_cnt), 32'(tv[i].e_cnt));
    end

    // Full auto job: 4 warn, 5 run, 3 dwell, 5 run, then IDLE on the 17th edge.
    set_in(0, 0, 0, 1, 0, 5, 2); cyc();
    set_in(1, 0, 0, 1, 0, 5, 2); cyc();
    spin_got = '0; warn_got = '0; done_seen = 1'b0;
    spin_got[0] = spindle_en; warn_got[0] = warn_lamp; done_seen = cycle_done;
    set_in(0, 0, 0, 1, 0, 5, 2);
    for (int i = 1; i < 17; i++) begin
      cyc();
      spin_got[i] = spindle_en; warn_got[i] = warn_lamp; done_seen |= cycle_done;
    end
    spin_exp = 17'b11111_000_11111_0000;
    warn_exp = 17'b00000_000_00000_1111;
    check("auto spindle pattern", 32'(spin_got), 32'(spin_exp));
    check("auto warn pattern", 32'(warn_got), 32'(warn_exp));
    check("auto early done", 32'(done_seen), 0);
    cyc();
    check("auto end state", 32'(state), 0);
    check("auto end done", 32'(cycle_done), 1);
    check("auto end cnt", 32'(cycle_cnt), 2);
    cyc();
    check("auto done one-shot", 32'(cycle_done), 0);

    // Estop during AUTO_RUN, then reset acknowledge.
    set_in(1, 0, 0, 1, 0, 5, 3); cyc();
    set_in(0, 0, 0, 1, 0, 5, 3);
    for (int i = 0; i < 5; i++) cyc();
    check("estop pre run", 32'(state), 3);
    set_in(0, 0, 1, 1, 0, 5, 3); cyc();
    check("estop spindle", 32'(spindle_en), 0);
    check("estop fault", 32'(fault), 1);
    set_in(0, 1, 1, 1, 0, 5, 3); cyc();
    check("estop+stop stays", 32'(state), 5);
    set_in(0, 1, 0, 1, 0, 5, 3); cyc();
    check("ack state", 32'(state), 0);
    check("ack fault", 32'(fault), 0);
    set_in(0, 0, 0, 1, 0, 5, 3); cyc();

    // Start held for 50 cycles in manual, then stop with start still high.
    set_in(1, 0, 0, 0, 1, 5, 3);
    for (int i = 0; i < 50; i++) cyc();
    check("held start running", 32'(state), 1);
    set_in(1, 1, 0, 0, 1, 5, 3); cyc();
    set_in(1, 0, 0, 0, 1, 5, 3);
    for (int i = 0; i < 5; i++) cyc();
    check("held start no restart", 32'(state), 0);
    check("held start spindle", 32'(spindle_en), 0);
    set_in(0, 0, 0, 0, 1, 5, 3); cyc();

    // Drop auto_mode during AUTO_DWELL.
    set_in(1, 0, 0, 1, 0, 2, 3); cyc();
    set_in(0, 0, 0, 1, 0, 2, 3);
    for (int i = 0; i < 6; i++) cyc();
    check("abort pre dwell", 32'(state), 4);
    set_in(0, 0, 0, 0, 0, 2, 3); cyc();
    check("abort state", 32'(state), 0);
    check("abort spindle", 32'(spindle_en), 0);
    check("abort done", 32'(cycle_done), 0);
    check("abort cnt kept", 32'(cycle_cnt), 1);

    // Asynchronous reset mid AUTO_RUN, off a clock edge, then a fresh job.
    set_in(1, 0, 0, 1, 0, 5, 2); cyc();
    set_in(0, 0, 0, 1, 0, 5, 2);
    for (int i = 0; i < 6; i++) cyc();
    check("arst pre spindle", 32'(spindle_en), 1);
    #3 rst = 1'b1;
    #1;
    check("arst spindle", 32'(spindle_en), 0);
    check("arst state", 32'(state), 0);
    check("arst warn", 32'(warn_lamp), 0);
    check("arst fault", 32'(fault), 0);
    check("arst done", 32'(cycle_done), 0);
    check("arst cnt", 32'(cycle_cnt), 0);
    model_reset();
    @(posedge clk);
    #4 rst = 1'b0;
    set_in(1, 0, 0, 1, 0, 5, 2); cyc();
    check("post-rst job state", 32'(state), 2);
    check("post-rst job cnt", 32'(cycle_cnt), 0);
    set_in(0, 0, 0, 1, 0, 5, 2);
    for (int i = 0; i < 17; i++) cyc();
    check("post-rst job end state", 32'(state), 0);
    check("post-rst job end cnt", 32'(cycle_cnt), 2);

    // Random operation against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        mr = 3'($urandom_range(0, 5));
        auto_mode = (mr <= 3'd2) || (mr == 3'd4);
        man_mode  = (mr == 3'd3) || (mr == 3'd4);
      end
      if ($urandom_range(0, 3) == 0) start = ~start;
      stop      = ($urandom_range(0, 49) == 0);
      estop     = ($urandom_range(0, 299) == 0);
      run_ticks = TW'($urandom_range(0, 6));
      n_reps    = CW'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
